// File: rtl/aes_sbox_bist_if.sv
// Byte-wide bus between the BIST engine and the S-box under test.
// The master drives the operand and direction, and the slave returns the combinational result.
interface aes_sbox_bist_if;
  logic [7:0] sbox_data_in;
  logic       sbox_enc_dec;
  logic [7:0] sbox_data_out;

  modport master (
    output sbox_data_in,
    output sbox_enc_dec,
    input  sbox_data_out
  );

  modport slave (
    input  sbox_data_in,
    input  sbox_enc_dec,
    output sbox_data_out
  );
endinterface

// File: rtl/aes_sbox_bist.sv
// Self-test sweep for an AES S-box. Each byte gets one forward cycle and one inverse cycle.
// The engine reports known-answer, duplicate-output and round-trip failures, plus a CRC-16 MISR signature.
module aes_sbox_bist (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  aes_sbox_bist_if.master        sbox,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [8:0]             fail_count,
  output logic [7:0]             first_fail_addr,
  output logic [1:0]             first_fail_kind,
  output logic [15:0]            signature
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_INV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state_reg;
  logic [7:0]   x_reg;
  logic [255:0] seen_reg;
  logic         kat_reg;
  logic         dup_reg;

  logic [7:0]       y;
  logic             kat_fail;
  logic             rt_fail;
  logic             any_fail;
  logic [1:0]       kind_next;
  logic [8:0][15:0] crc_chain;

  assign y = sbox.sbox_data_out;

  always_comb begin
    kat_fail = 1'b0;
    case (x_reg)
      8'h00:   kat_fail = (y != 8'h63);
      8'h53:   kat_fail = (y != 8'hED);
      8'hAA:   kat_fail = (y != 8'hAC);
      8'hFF:   kat_fail = (y != 8'h16);
      default: kat_fail = 1'b0;
    endcase
  end

  // One MSB-first CRC-16-CCITT step per input bit. This unrolls into a single-cycle byte update.
  assign crc_chain[0] = signature;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_crc
      logic fb;
      assign fb = crc_chain[gi][15] ^ y[7-gi];
      assign crc_chain[gi+1] = {crc_chain[gi][14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
  endgenerate

  // In INV the S-box input holds the forward result, so a good part returns x.
  assign rt_fail   = (y != x_reg);
  assign any_fail  = kat_reg | dup_reg | rt_fail;
  assign kind_next = kat_reg ? 2'b11 : (dup_reg ? 2'b10 : 2'b01);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      x_reg             <= 8'h00;
      seen_reg          <= '0;
      kat_reg           <= 1'b0;
      dup_reg           <= 1'b0;
      sbox.sbox_data_in <= 8'h00;
      sbox.sbox_enc_dec <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      pass              <= 1'b0;
      fail_count        <= 9'd0;
      first_fail_addr   <= 8'h00;
      first_fail_kind   <= 2'b00;
      signature         <= 16'hFFFF;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          sbox.sbox_data_in <= 8'h00;
          sbox.sbox_enc_dec <= 1'b1;
          if (start) begin
            state_reg       <= S_FWD;
            x_reg           <= 8'h00;
            seen_reg        <= '0;
            kat_reg         <= 1'b0;
            dup_reg         <= 1'b0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= 9'd0;
            first_fail_addr <= 8'h00;
            first_fail_kind <= 2'b00;
            signature       <= 16'hFFFF;
          end
        end

        S_FWD: begin
          kat_reg           <= kat_fail;
          dup_reg           <= seen_reg[y];
          seen_reg[y]       <= 1'b1;
          signature         <= crc_chain[8];
          sbox.sbox_data_in <= y;
          sbox.sbox_enc_dec <= 1'b0;
          state_reg         <= S_INV;
        end

        S_INV: begin
          if (any_fail) begin
            fail_count <= fail_count + 9'd1;
            if (fail_count == 9'd0) begin
              first_fail_addr <= x_reg;
              first_fail_kind <= kind_next;
            end
          end
          sbox.sbox_enc_dec <= 1'b1;
          if (x_reg == 8'hFF) begin
            state_reg         <= S_DONE;
            busy              <= 1'b0;
            done              <= 1'b1;
            pass              <= (fail_count == 9'd0) && !any_fail;
            sbox.sbox_data_in <= 8'h00;
          end else begin
            state_reg         <= S_FWD;
            x_reg             <= x_reg + 8'd1;
            sbox.sbox_data_in <= x_reg + 8'd1;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sbox_bist.sv
// Bench for aes_sbox_bist. A table-driven S-box is built from GF(2^8) arithmetic, and faults are injected into it.
// A whole-sweep model predicts what the BIST engine should report.
module tb_aes_sbox_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, pass;
  logic [8:0]  fail_count;
  logic [7:0]  first_fail_addr;
  logic [1:0]  first_fail_kind;
  logic [15:0] signature;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] gold_fwd [256];
  logic [7:0] gold_inv [256];
  logic [7:0] fwd_tab  [256];
  logic [7:0] inv_tab  [256];

  aes_sbox_bist_if bus ();

  assign bus.sbox_data_out = bus.sbox_enc_dec ? fwd_tab[bus.sbox_data_in] : inv_tab[bus.sbox_data_in];

  aes_sbox_bist dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .sbox            (bus.master),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_count      (fail_count),
    .first_fail_addr (first_fail_addr),
    .first_fail_kind (first_fail_kind),
    .signature       (signature)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c = c_in ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic build_gold();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv_a = 8'h00;
      logic [7:0] av = a[7:0];
      logic [7:0] s;
      for (int b = 1; b < 256; b++)
        if (gf_mul(av, b[7:0]) == 8'h01) inv_a = b[7:0];
      s = inv_a ^ rotl8(inv_a, 1) ^ rotl8(inv_a, 2) ^ rotl8(inv_a, 3) ^ rotl8(inv_a, 4) ^ 8'h63;
      gold_fwd[a] = s;
      gold_inv[s] = av;
    end
  endtask

  task automatic restore_tables();
    for (int i = 0; i < 256; i++) begin
      fwd_tab[i] = gold_fwd[i];
      inv_tab[i] = gold_inv[i];
    end
  endtask

  // Whole-sweep prediction straight from the check rules.
  task automatic model_run(output logic [8:0] m_fail, output logic [7:0] m_addr,
                           output logic [1:0] m_kind, output logic m_pass, output logic [15:0] m_sig);
    logic [7:0] kat_x [4] = '{8'h00, 8'h53, 8'hAA, 8'hFF};
    logic [7:0] kat_y [4] = '{8'h63, 8'hED, 8'hAC, 8'h16};
    bit seen [256];
    m_fail = 0; m_addr = 0; m_kind = 0; m_sig = 16'hFFFF;
    for (int i = 0; i < 256; i++) seen[i] = 0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] y = fwd_tab[x];
      bit kat = 0, dup, rt;
      for (int k = 0; k < 4; k++) if (kat_x[k] == x[7:0] && kat_y[k] != y) kat = 1;
      dup = seen[y];
      seen[y] = 1;
      m_sig = crc_byte(m_sig, y);
      rt = (inv_tab[y] != x[7:0]);
      if (kat || dup || rt) begin
        if (m_fail == 0) begin
          m_addr = x[7:0];
          m_kind = kat ? 2'b11 : (dup ? 2'b10 : 2'b01);
        end
        m_fail++;
      end
    end
    m_pass = (m_fail == 0);
  endtask

  // Pulses start for one cycle, then watches the sweep one cycle at a time. k counts cycles after the start edge.
  task automatic run_sweep(input int repulse_k, input int rst_k,
                           output int busy_cnt, output int done_k, output logic done_k1);
    busy_cnt = 0; done_k = 0; done_k1 = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      if (k == 1) done_k1 = done;
      if (busy) busy_cnt++;
      if (done) begin
        done_k = k;
        break;
      end
      start = (k == repulse_k);
      if (k == rst_k) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail_count"}, fail_count, 0);
    chk({tag, "_first_addr"}, first_fail_addr, 0);
    chk({tag, "_first_kind"}, first_fail_kind, 0);
    chk({tag, "_signature"}, signature, 16'hFFFF);
    chk({tag, "_data_in"}, bus.sbox_data_in, 0);
    chk({tag, "_enc_dec"}, bus.sbox_enc_dec, 1);
  endtask

  task automatic sweep_and_compare(input string tag, input int repulse_k);
    int busy_cnt, done_k;
    logic done_k1;
    logic [8:0] m_fail; logic [7:0] m_addr; logic [1:0] m_kind; logic m_pass; logic [15:0] m_sig;
    model_run(m_fail, m_addr, m_kind, m_pass, m_sig);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    run_sweep(repulse_k, 0, busy_cnt, done_k, done_k1);
    chk({tag, "_busy_cycles"}, busy_cnt, 512);
    chk({tag, "_done_cycle"}, done_k, 513);
    chk({tag, "_done_low_first"}, done_k1, 0);
    chk({tag, "_pass"}, pass, m_pass);
    chk({tag, "_fail_count"}, fail_count, m_fail);
    chk({tag, "_first_addr"}, first_fail_addr, m_addr);
    chk({tag, "_first_kind"}, first_fail_kind, m_kind);
    chk({tag, "_signature"}, signature, m_sig);
    $display("sweep %s: fail_count=%0d first=0x%02h kind=%0d pass=%0d sig=0x%04h",
             tag, fail_count, first_fail_addr, first_fail_kind, pass, signature);
  endtask

  initial begin
    int busy_cnt, done_k;
    logic done_k1;
    rst = 1'b1; start = 1'b0;
    build_gold();
    restore_tables();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    sweep_and_compare("golden", 0);
    sweep_and_compare("back_to_back", 0);
    sweep_and_compare("start_repulse", 100);

    repeat (2) @(negedge clk);
    run_sweep(0, 200, busy_cnt, done_k, done_k1);
    check_reset_vals("mid_rst");
    $display("sweep mid_rst: aborted at cycle 200");
    sweep_and_compare("after_rst", 0);

    fwd_tab[8'h53] = 8'h00;
    sweep_and_compare("fault_fwd53", 0);
    chk("fault_fwd53_fixed_count", fail_count, 1);
    chk("fault_fwd53_fixed_addr", first_fail_addr, 8'h53);
    chk("fault_fwd53_fixed_kind", first_fail_kind, 2'b11);
    restore_tables();

    inv_tab[8'h7C] = 8'h7C;
    sweep_and_compare("fault_inv7c", 0);
    chk("fault_inv7c_fixed_addr", first_fail_addr, 8'h01);
    chk("fault_inv7c_fixed_kind", first_fail_kind, 2'b01);
    restore_tables();

    fwd_tab[8'h10] = 8'h63;
    sweep_and_compare("fault_dup10", 0);
    chk("fault_dup10_fixed_addr", first_fail_addr, 8'h10);
    chk("fault_dup10_fixed_kind", first_fail_kind, 2'b10);
    restore_tables();

    for (int r = 0; r < 6; r++) begin
      logic [7:0] a = 8'($urandom_range(0, 255));
      logic [7:0] v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) fwd_tab[a] = v;
      else inv_tab[a] = v;
      sweep_and_compare($sformatf("random%0d", r), 0);
      restore_tables();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
